game_timer: RTL and testbench

- Parametrised successor of the fixed 60 s game timer: configurable clock rate, duration, count direction and warning window.
- Adds pause/resume, restart and a warning flag.
- Keeps the time directly as three BCD digit counters, so no separate binary-to-BCD converter is needed.
- Sits between the debounced start/pause buttons and the 7-segment mux; Finish gates the mole game logic.

---
 rtl/game_timer.sv | 142 ++++++++++++++
 tb/tb_game_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Game countdown/countup timer: prescaled one-second ticks stepping three BCD
// digits directly, with pause/resume, restart, warning window and finish flags.
module game_timer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DURATION   = 60,
    parameter int COUNT_DOWN = 1,
    parameter int WARN_SECS  = 10
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] Hundreds,
    output logic [3:0] Tens,
    output logic [3:0] Ones,
    output logic       running,
    output logic       paused,
    output logic       Finish,
    output logic       finish_pulse,
    output logic       sec_tick,
    output logic       warn
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int RW = $clog2(DURATION + 1);

    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] REM_INIT = RW'(DURATION);
    localparam logic [RW-1:0] WARN_LIM = RW'(WARN_SECS);

    localparam logic [3:0] LOAD_H = (COUNT_DOWN != 0) ? 4'(DURATION / 100)       : 4'd0;
    localparam logic [3:0] LOAD_T = (COUNT_DOWN != 0) ? 4'((DURATION / 10) % 10) : 4'd0;
    localparam logic [3:0] LOAD_O = (COUNT_DOWN != 0) ? 4'(DURATION % 10)        : 4'd0;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [RW-1:0] rem;
    logic          tick;
    logic [3:0]    step_h, step_t, step_o;

    assign tick     = (state == RUN) && (presc == PRE_MAX);
    assign sec_tick = tick;
    assign warn     = ((state == RUN) || (state == PAUSED)) && (rem <= WARN_LIM);

    // One BCD step of the displayed value; only applied while rem > 0, so the
    // down count never borrows past 000 and the up count never passes 999.
    always_comb begin
        step_h = Hundreds;
        step_t = Tens;
        step_o = Ones;
        if (COUNT_DOWN != 0) begin
            if (Ones != 4'd0) begin
                step_o = Ones - 4'd1;
            end else begin
                step_o = 4'd9;
                if (Tens != 4'd0) begin
                    step_t = Tens - 4'd1;
                end else begin
                    step_t = 4'd9;
                    step_h = Hundreds - 4'd1;
                end
            end
        end else begin
            if (Ones != 4'd9) begin
                step_o = Ones + 4'd1;
            end else begin
                step_o = 4'd0;
                if (Tens != 4'd9) begin
                    step_t = Tens + 4'd1;
                end else begin
                    step_t = 4'd0;
                    step_h = Hundreds + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= IDLE;
            presc        <= '0;
            rem          <= REM_INIT;
            Hundreds     <= LOAD_H;
            Tens         <= LOAD_T;
            Ones         <= LOAD_O;
            running      <= 1'b0;
            paused       <= 1'b0;
            Finish       <= 1'b0;
            finish_pulse <= 1'b0;
        end else begin
            finish_pulse <= 1'b0;
            if (start) begin
                // start outranks everything, including a same-cycle tick
                state    <= RUN;
                presc    <= '0;
                rem      <= REM_INIT;
                Hundreds <= LOAD_H;
                Tens     <= LOAD_T;
                Ones     <= LOAD_O;
                running  <= 1'b1;
                paused   <= 1'b0;
                Finish   <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (tick) begin
                            presc    <= '0;
                            rem      <= rem - 1'b1;
                            Hundreds <= step_h;
                            Tens     <= step_t;
                            Ones     <= step_o;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        // reaching zero beats a same-cycle pause
                        if (tick && (rem == RW'(1))) begin
                            state        <= DONE;
                            running      <= 1'b0;
                            Finish       <= 1'b1;
                            finish_pulse <= 1'b1;
                        end else if (pause) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a per-cycle vector table on a small down
// counter, plus full-run, restart, reset and BCD carry/borrow sequences.
module tb_game_timer;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic start_a = 1'b0, pause_a = 1'b0;
    logic start_bc = 1'b0, pause_bc = 1'b0;

    logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b, h_c, t_c, o_c;
    logic run_a, pau_a, fin_a, fp_a, tk_a, wn_a;
    logic run_b, pau_b, fin_b, fp_b, tk_b, wn_b;
    logic run_c, pau_c, fin_c, fp_c, tk_c, wn_c;

    logic [17:0] out_a, out_b, out_c;
    assign out_a = {h_a, t_a, o_a, run_a, pau_a, fin_a, fp_a, tk_a, wn_a};
    assign out_b = {h_b, t_b, o_b, run_b, pau_b, fin_b, fp_b, tk_b, wn_b};
    assign out_c = {h_c, t_c, o_c, run_c, pau_c, fin_c, fp_c, tk_c, wn_c};

    always #5 Clk = ~Clk;

    game_timer #(.CLK_HZ(4), .DURATION(12), .COUNT_DOWN(1), .WARN_SECS(10)) dut_a (
        .Clk(Clk), .Rst(Rst), .start(start_a), .pause(pause_a),
        .Hundreds(h_a), .Tens(t_a), .Ones(o_a), .running(run_a), .paused(pau_a),
        .Finish(fin_a), .finish_pulse(fp_a), .sec_tick(tk_a), .warn(wn_a));

    game_timer #(.CLK_HZ(2), .DURATION(100), .COUNT_DOWN(1), .WARN_SECS(10)) dut_b (
        .Clk(Clk), .Rst(Rst), .start(start_bc), .pause(pause_bc),
        .Hundreds(h_b), .Tens(t_b), .Ones(o_b), .running(run_b), .paused(pau_b),
        .Finish(fin_b), .finish_pulse(fp_b), .sec_tick(tk_b), .warn(wn_b));

    game_timer #(.CLK_HZ(2), .DURATION(100), .COUNT_DOWN(0), .WARN_SECS(10)) dut_c (
        .Clk(Clk), .Rst(Rst), .start(start_bc), .pause(pause_bc),
        .Hundreds(h_c), .Tens(t_c), .Ones(o_c), .running(run_c), .paused(pau_c),
        .Finish(fin_c), .finish_pulse(fp_c), .sec_tick(tk_c), .warn(wn_c));

    typedef struct {
        logic        rst;
        logic        start;
        logic        pause;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs [0:39];
    int   nv = 0;
    int   total = 0;
    int   bad = 0;

    function automatic logic [17:0] mk(int h, int t, int o, bit run, bit pau,
                                       bit fin, bit fp, bit tk, bit wn);
        return {4'(h), 4'(t), 4'(o), run, pau, fin, fp, tk, wn};
    endfunction

    task automatic add(input logic rst, input logic st, input logic pa, input logic [17:0] e);
        vecs[nv].rst   = rst;
        vecs[nv].start = st;
        vecs[nv].pause = pa;
        vecs[nv].exp   = e;
        nv++;
    endtask

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got H%0d T%0d O%0d flags(run,pau,fin,fp,tick,warn)=%06b, want H%0d T%0d O%0d flags=%06b",
                     name, got[17:14], got[13:10], got[9:6], got[5:0],
                     exp[17:14], exp[13:10], exp[9:6], exp[5:0]);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // rst start pause | H T O run pau fin fp tick warn
        add(0, 0, 0, mk(0, 1, 2, 0, 0, 0, 0, 0, 0));  // reset
        add(1, 0, 0, mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        add(1, 0, 1, mk(0, 1, 2, 0, 0, 0, 0, 0, 0));  // pause ignored in IDLE
        add(1, 1, 0, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));  // start, presc 0
        add(1, 0, 0, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 1, 2, 1, 0, 0, 0, 1, 0));  // tick cycle
        add(1, 0, 0, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));  // 011
        add(1, 0, 0, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        add(1, 0, 1, mk(0, 1, 1, 0, 1, 0, 0, 0, 0));  // pause, presc -> 2
        add(1, 0, 0, mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
        add(1, 0, 1, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));  // resume at presc 2
        add(1, 0, 0, mk(0, 1, 1, 1, 0, 0, 0, 1, 0));
        add(1, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 1));  // 010, warn on
        add(1, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        add(1, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        add(1, 0, 1, mk(0, 1, 0, 0, 1, 0, 0, 0, 1));  // pause, presc -> 3
        add(1, 0, 1, mk(0, 1, 0, 1, 0, 0, 0, 1, 1));  // resume onto tick
        add(1, 0, 1, mk(0, 0, 9, 0, 1, 0, 0, 0, 1));  // pause on tick: step then PAUSED
        add(1, 0, 1, mk(0, 0, 9, 1, 0, 0, 0, 0, 1));
        add(1, 0, 0, mk(0, 0, 9, 1, 0, 0, 0, 0, 1));
        add(1, 0, 0, mk(0, 0, 9, 1, 0, 0, 0, 0, 1));
        add(1, 0, 0, mk(0, 0, 9, 1, 0, 0, 0, 1, 1));
        add(1, 1, 0, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));  // start on tick: reload only
        add(1, 0, 0, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        add(1, 1, 1, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));  // start+pause: reload, RUN

        #2;
        for (int i = 0; i < nv; i++) begin
            Rst     = vecs[i].rst;
            start_a = vecs[i].start;
            pause_a = vecs[i].pause;
            cyc();
            chk($sformatf("vec%0d", i), out_a, vecs[i].exp);
        end
        Rst = 1'b1; start_a = 1'b0; pause_a = 1'b0;

        // full 12 s run from a fresh restart
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        chk("run_start", out_a, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 48; i++) begin
            int r;
            cyc();
            r = 12 - i / 4;
            chk($sformatf("run_c%0d", i), out_a,
                mk(0, r / 10, r % 10, i < 48, 0, i >= 48, i == 48, (i % 4) == 3,
                   (i < 48) && (r <= 10)));
        end
        cyc();
        chk("done_hold", out_a, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        pause_a = 1'b1;
        cyc();
        pause_a = 1'b0;
        chk("done_pause_ign", out_a, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 6; i++) cyc();
        chk("done_frozen", out_a, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

        // restart from DONE, then reset mid-count
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        chk("restart_done", out_a, mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) cyc();
        chk("mid_run", out_a, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        Rst = 1'b0;
        cyc();
        Rst = 1'b1;
        chk("mid_reset", out_a, mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("idle_quiet%0d", i), out_a, mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        end

        // DURATION=100 borrow (down) and carry (up) at CLK_HZ=2
        chk("bc_idle_b", out_b, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("bc_idle_c", out_c, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_bc = 1'b1;
        cyc();
        start_bc = 1'b0;
        for (int i = 1; i <= 201; i++) begin
            cyc();
            if (i == 1)   chk("b_100",  out_b, mk(1, 0, 0, 1, 0, 0, 0, 1, 0));
            if (i == 2)   chk("b_099",  out_b, mk(0, 9, 9, 1, 0, 0, 0, 0, 0));
            if (i == 4)   chk("b_098",  out_b, mk(0, 9, 8, 1, 0, 0, 0, 0, 0));
            if (i == 200) chk("b_done", out_b, mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
            if (i == 18)  chk("c_009",  out_c, mk(0, 0, 9, 1, 0, 0, 0, 0, 0));
            if (i == 20)  chk("c_010",  out_c, mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
            if (i == 198) chk("c_099",  out_c, mk(0, 9, 9, 1, 0, 0, 0, 0, 1));
            if (i == 200) chk("c_100",  out_c, mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
            if (i == 201) chk("c_hold", out_c, mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
